// File: rtl/coin_report_sched.sv
// Coin-count report frame scheduler: merges count-change and user
// requests and streams a 17-byte CSV frame to a byte-wide UART TX.
module coin_report_sched #(
  parameter int HOLDOFF = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  change,
  input  logic        report_req,
  input  logic [23:0] field0,
  input  logic [23:0] field1,
  input  logic [23:0] field2,
  input  logic [23:0] field3,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        pending,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam int GW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GAP
  } state_t;

  state_t        state;
  logic [95:0]   snap;
  logic [4:0]    idx;
  logic [GW-1:0] gap;
  logic          req_any;

  assign req_any = (|change) | report_req;

  // Frame layout: three digits per field, comma between fields, CR LF tail
  function automatic logic [7:0] frame_byte(
    input logic [95:0] s,
    input logic [4:0]  i
  );
    logic [23:0] f;
    logic [7:0]  b;
    unique case (i[3:2])
      2'd0:    f = s[95:72];
      2'd1:    f = s[71:48];
      2'd2:    f = s[47:24];
      default: f = s[23:0];
    endcase
    if (i == 5'd16)           b = 8'h0A;
    else if (i == 5'd15)      b = 8'h0D;
    else if (i[1:0] == 2'd3)  b = 8'h2C;
    else if (i[1:0] == 2'd0)  b = f[23:16];
    else if (i[1:0] == 2'd1)  b = f[15:8];
    else                      b = f[7:0];
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      pending     <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'h00;
      snap        <= '0;
      idx         <= '0;
      gap         <= '0;
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_any || pending) begin
            snap     <= {field0, field1, field2, field3};
            pending  <= 1'b0;
            idx      <= 5'd0;
            tx_start <= 1'b1;
            tx_data  <= field0[23:16];
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (req_any) pending <= 1'b1;
          if (tx_done) begin
            if (idx < 5'd16) begin
              idx      <= idx + 5'd1;
              tx_start <= 1'b1;
              tx_data  <= frame_byte(snap, idx + 5'd1);
            end else begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
              gap         <= GW'(HOLDOFF);
              if (HOLDOFF == 0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (req_any) pending <= 1'b1;
          gap <= gap - GW'(1);
          if (gap == GW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
